// File: rtl/cpu_controller.sv
// Instruction register, decoder and Moore control FSM for the simple RISC CPU datapath.
// Optional conditional branches (opcode 001) are enabled by defining CPU_BRANCH_EN.
module cpu_controller #(
    parameter int unsigned READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mem_rdata,
    input  logic [2:0]  status_in,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic [1:0]  bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [1:0]  mem_cmd,
    output logic        addr_sel,
    output logic        load_addr,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        pc_branch,
    output logic        halted
);

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPDATE_PC,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG,
        S_ADDR,
        S_LOAD_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_GET_RD,
        S_PASS_B,
        S_MEM_WR,
        S_BRANCH,
        S_HALT
    } state_t;

    localparam logic [3:0] C_WAIT_RELOAD = 4'(READ_WAIT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic [3:0]  r_wait;

    logic [2:0]  w_opcode;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;
    logic        w_is_cmp;
    logic        w_a_zero;
    logic        w_entering_wait;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign w_is_cmp = (w_opcode == 3'b101) && (w_op == 2'b01);
    // MOV Rd,Rm and MVN route a constant zero into ALU input A
    assign w_a_zero = (w_opcode == 3'b110) || ((w_opcode == 3'b101) && (w_op == 2'b11));

    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

`ifdef CPU_BRANCH_EN
    logic w_br_valid;
    logic w_br_take;
    logic w_z;
    logic w_n;
    logic w_v;

    assign w_z = status_in[0];
    assign w_n = status_in[1];
    assign w_v = status_in[2];

    always_comb begin
        w_br_valid = 1'b1;
        w_br_take  = 1'b0;
        case (w_rn)
            3'b000:  w_br_take = 1'b1;
            3'b001:  w_br_take = w_z;
            3'b010:  w_br_take = !w_z;
            3'b011:  w_br_take = (w_n != w_v);
            3'b100:  w_br_take = (w_n != w_v) || w_z;
            default: w_br_valid = 1'b0;
        endcase
    end
`else
    logic w_unused_status;
    assign w_unused_status = ^status_in;
`endif

    assign w_entering_wait = ((w_next == S_IF1) && (r_state != S_IF1)) ||
                             ((w_next == S_MEM_RD) && (r_state != S_MEM_RD));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RST;
            r_ir    <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (load_ir) begin
                r_ir <= mem_rdata;
            end
            if (w_entering_wait) begin
                r_wait <= C_WAIT_RELOAD;
            end else if (((r_state == S_IF1) || (r_state == S_MEM_RD)) && (r_wait != '0)) begin
                r_wait <= r_wait - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:       w_next = S_IF1;
            S_IF1:       w_next = (r_wait == '0) ? S_IF2 : S_IF1;
            S_IF2:       w_next = S_UPDATE_PC;
            S_UPDATE_PC: w_next = S_DECODE;
            S_DECODE: begin
                casez ({w_opcode, w_op})
                    5'b110_10: w_next = S_WRITE_IMM;
                    5'b110_00: w_next = S_GET_B;
                    5'b101_11: w_next = S_GET_B;
                    5'b101_00,
                    5'b101_01,
                    5'b101_10: w_next = S_GET_A;
                    5'b011_00: w_next = S_GET_A;
                    5'b100_00: w_next = S_GET_A;
`ifdef CPU_BRANCH_EN
                    5'b001_??: begin
                        if (!w_br_valid) begin
                            w_next = S_HALT;
                        end else begin
                            w_next = w_br_take ? S_BRANCH : S_IF1;
                        end
                    end
`endif
                    default:   w_next = S_HALT;
                endcase
            end
            S_WRITE_IMM: w_next = S_IF1;
            S_GET_A:     w_next = (w_opcode == 3'b101) ? S_GET_B : S_ADDR;
            S_GET_B:     w_next = S_EXEC;
            S_EXEC:      w_next = w_is_cmp ? S_IF1 : S_WRITE_REG;
            S_WRITE_REG: w_next = S_IF1;
            S_ADDR:      w_next = S_LOAD_ADDR;
            S_LOAD_ADDR: w_next = (w_opcode == 3'b011) ? S_MEM_RD : S_GET_RD;
            S_MEM_RD:    w_next = (r_wait == '0) ? S_WB_MEM : S_MEM_RD;
            S_WB_MEM:    w_next = S_IF1;
            S_GET_RD:    w_next = S_PASS_B;
            S_PASS_B:    w_next = S_MEM_WR;
            S_MEM_WR:    w_next = S_IF1;
            S_BRANCH:    w_next = S_IF1;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_HALT;
        endcase
    end

    always_comb begin
        readnum   = w_rn;
        writenum  = w_rd;
        shift     = w_sh;
        write     = 1'b0;
        vsel      = 2'b00;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 2'b00;
        ALUop     = 2'b00;
        mem_cmd   = 2'b00;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        pc_branch = 1'b0;
        halted    = 1'b0;
        case (r_state)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                mem_cmd  = 2'b01;
                addr_sel = 1'b1;
            end
            S_IF2: begin
                mem_cmd  = 2'b01;
                addr_sel = 1'b1;
                load_ir  = 1'b1;
            end
            S_UPDATE_PC: load_pc = 1'b1;
            S_WRITE_IMM: begin
                vsel     = 2'b11;
                writenum = w_rn;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                asel  = w_a_zero;
                ALUop = w_op;
                loads = w_is_cmp;
                loadc = !w_is_cmp;
            end
            S_WRITE_REG: begin
                writenum = w_rd;
                write    = 1'b1;
            end
            S_ADDR: begin
                bsel  = 2'b01;
                loadc = 1'b1;
            end
            S_LOAD_ADDR: load_addr = 1'b1;
            S_MEM_RD:    mem_cmd   = 2'b01;
            S_WB_MEM: begin
                mem_cmd  = 2'b01;
                vsel     = 2'b10;
                writenum = w_rd;
                write    = 1'b1;
            end
            S_GET_RD: begin
                readnum = w_rd;
                loadb   = 1'b1;
            end
            S_PASS_B: begin
                asel  = 1'b1;
                shift = 2'b00;
                loadc = 1'b1;
            end
            S_MEM_WR: mem_cmd = 2'b10;
`ifdef CPU_BRANCH_EN
            S_BRANCH: begin
                load_pc   = 1'b1;
                pc_branch = 1'b1;
            end
`endif
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: instance A (READ_WAIT=1) runs the instruction mix,
// instance B (READ_WAIT=3) runs an LDR to exercise the wait counter.
module tb_cpu_controller;

    typedef struct packed {
        logic       write;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic [1:0] bsel;
        logic [1:0] ALUop;
        logic [1:0] mem_cmd;
        logic       addr_sel;
        logic       load_addr;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       pc_branch;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t C_NONE     = '0;
    localparam ctrl_t C_RST      = '{reset_pc: 1'b1, load_pc: 1'b1, default: '0};
    localparam ctrl_t C_IF1      = '{mem_cmd: 2'b01, addr_sel: 1'b1, default: '0};
    localparam ctrl_t C_IF2      = '{mem_cmd: 2'b01, addr_sel: 1'b1, load_ir: 1'b1, default: '0};
    localparam ctrl_t C_UPD      = '{load_pc: 1'b1, default: '0};
    localparam ctrl_t C_WIMM     = '{write: 1'b1, vsel: 2'b11, default: '0};
    localparam ctrl_t C_GETA     = '{loada: 1'b1, default: '0};
    localparam ctrl_t C_GETB     = '{loadb: 1'b1, default: '0};
    localparam ctrl_t C_EXEC_ADD = '{loadc: 1'b1, default: '0};
    localparam ctrl_t C_EXEC_CMP = '{loads: 1'b1, ALUop: 2'b01, default: '0};
    localparam ctrl_t C_EXEC_MOV = '{asel: 1'b1, loadc: 1'b1, default: '0};
    localparam ctrl_t C_EXEC_MVN = '{asel: 1'b1, loadc: 1'b1, ALUop: 2'b11, default: '0};
    localparam ctrl_t C_WREG     = '{write: 1'b1, default: '0};
    localparam ctrl_t C_ADDR     = '{bsel: 2'b01, loadc: 1'b1, default: '0};
    localparam ctrl_t C_LADDR    = '{load_addr: 1'b1, default: '0};
    localparam ctrl_t C_MEMRD    = '{mem_cmd: 2'b01, default: '0};
    localparam ctrl_t C_WBMEM    = '{mem_cmd: 2'b01, vsel: 2'b10, write: 1'b1, default: '0};
    localparam ctrl_t C_GETRD    = '{loadb: 1'b1, default: '0};
    localparam ctrl_t C_PASSB    = '{asel: 1'b1, loadc: 1'b1, default: '0};
    localparam ctrl_t C_MEMWR    = '{mem_cmd: 2'b10, default: '0};
    localparam ctrl_t C_HALT     = '{halted: 1'b1, default: '0};
`ifdef CPU_BRANCH_EN
    localparam ctrl_t C_BR       = '{load_pc: 1'b1, pc_branch: 1'b1, default: '0};
`endif

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n_a, reset_n_b;
    logic [15:0] mem_a, mem_b;
    logic [2:0]  status_a, status_b;

    logic [2:0]  a_readnum, a_writenum, b_readnum, b_writenum;
    logic        a_write, a_loada, a_loadb, a_loadc, a_loads, a_asel;
    logic        b_write, b_loada, b_loadb, b_loadc, b_loads, b_asel;
    logic [1:0]  a_vsel, a_bsel, a_shift, a_ALUop, a_mem_cmd;
    logic [1:0]  b_vsel, b_bsel, b_shift, b_ALUop, b_mem_cmd;
    logic [15:0] a_sximm8, a_sximm5, b_sximm8, b_sximm5;
    logic        a_addr_sel, a_load_addr, a_load_ir, a_load_pc, a_reset_pc, a_pc_branch, a_halted;
    logic        b_addr_sel, b_load_addr, b_load_ir, b_load_pc, b_reset_pc, b_pc_branch, b_halted;

    cpu_controller #(.READ_WAIT(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n_a), .mem_rdata(mem_a), .status_in(status_a),
        .readnum(a_readnum), .writenum(a_writenum), .write(a_write), .vsel(a_vsel),
        .loada(a_loada), .loadb(a_loadb), .loadc(a_loadc), .loads(a_loads),
        .asel(a_asel), .bsel(a_bsel), .shift(a_shift), .ALUop(a_ALUop),
        .sximm8(a_sximm8), .sximm5(a_sximm5), .mem_cmd(a_mem_cmd), .addr_sel(a_addr_sel),
        .load_addr(a_load_addr), .load_ir(a_load_ir), .load_pc(a_load_pc),
        .reset_pc(a_reset_pc), .pc_branch(a_pc_branch), .halted(a_halted)
    );

    cpu_controller #(.READ_WAIT(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n_b), .mem_rdata(mem_b), .status_in(status_b),
        .readnum(b_readnum), .writenum(b_writenum), .write(b_write), .vsel(b_vsel),
        .loada(b_loada), .loadb(b_loadb), .loadc(b_loadc), .loads(b_loads),
        .asel(b_asel), .bsel(b_bsel), .shift(b_shift), .ALUop(b_ALUop),
        .sximm8(b_sximm8), .sximm5(b_sximm5), .mem_cmd(b_mem_cmd), .addr_sel(b_addr_sel),
        .load_addr(b_load_addr), .load_ir(b_load_ir), .load_pc(b_load_pc),
        .reset_pc(b_reset_pc), .pc_branch(b_pc_branch), .halted(b_halted)
    );

    ctrl_t w_ca, w_cb;
    assign w_ca = {a_write, a_vsel, a_loada, a_loadb, a_loadc, a_loads, a_asel, a_bsel,
                   a_ALUop, a_mem_cmd, a_addr_sel, a_load_addr, a_load_ir, a_load_pc,
                   a_reset_pc, a_pc_branch, a_halted};
    assign w_cb = {b_write, b_vsel, b_loada, b_loadb, b_loadc, b_loads, b_asel, b_bsel,
                   b_ALUop, b_mem_cmd, b_addr_sel, b_load_addr, b_load_ir, b_load_pc,
                   b_reset_pc, b_pc_branch, b_halted};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the current control vector, then advance to the next falling edge.
    task automatic st(input bit b, input string tag, input ctrl_t e);
        chk(tag, b ? 32'(w_cb) : 32'(w_ca), 32'(e));
        @(negedge clk);
    endtask

    task automatic fetch(input bit b, input string p, input logic [15:0] instr,
                         input int unsigned nwait);
        if (b) mem_b = instr;
        else   mem_a = instr;
        for (int unsigned i = 0; i < nwait; i++) st(b, {p, ".if1"}, C_IF1);
        st(b, {p, ".if2"}, C_IF2);
        st(b, {p, ".upd"}, C_UPD);
        st(b, {p, ".dec"}, C_NONE);
    endtask

    initial begin
        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        mem_a     = '0;
        mem_b     = '0;
        status_a  = '0;
        status_b  = '0;
        repeat (3) @(negedge clk);

        chk("rst.readnum", 32'(a_readnum), 32'd0);
        chk("rst.sximm8", 32'(a_sximm8), 32'h0);
        st(0, "rst.ctrl", C_RST);
        reset_n_a = 1'b1;
        @(negedge clk);

        fetch(0, "movi", 16'hD001, 1);
        chk("movi.writenum", 32'(a_writenum), 32'd0);
        chk("movi.sximm8", 32'(a_sximm8), 32'h0001);
        st(0, "movi.wimm", C_WIMM);

        fetch(0, "add", 16'hA148, 1);
        chk("add.geta.readnum", 32'(a_readnum), 32'd1);
        st(0, "add.geta", C_GETA);
        chk("add.getb.readnum", 32'(a_readnum), 32'd0);
        st(0, "add.getb", C_GETB);
        chk("add.exec.shift", 32'(a_shift), 32'd1);
        st(0, "add.exec", C_EXEC_ADD);
        chk("add.wreg.writenum", 32'(a_writenum), 32'd2);
        st(0, "add.wreg", C_WREG);

        fetch(0, "cmp", 16'hA900, 1);
        st(0, "cmp.geta", C_GETA);
        st(0, "cmp.getb", C_GETB);
        st(0, "cmp.exec", C_EXEC_CMP);

        fetch(0, "mvn", 16'hB8E1, 1);
        chk("mvn.getb.readnum", 32'(a_readnum), 32'd1);
        st(0, "mvn.getb", C_GETB);
        st(0, "mvn.exec", C_EXEC_MVN);
        chk("mvn.wreg.writenum", 32'(a_writenum), 32'd7);
        st(0, "mvn.wreg", C_WREG);

        fetch(0, "movr", 16'hC0A3, 1);
        chk("movr.getb.readnum", 32'(a_readnum), 32'd3);
        st(0, "movr.getb", C_GETB);
        st(0, "movr.exec", C_EXEC_MOV);
        chk("movr.wreg.writenum", 32'(a_writenum), 32'd5);
        st(0, "movr.wreg", C_WREG);

        fetch(0, "str", 16'h8078, 1);
        chk("str.geta.readnum", 32'(a_readnum), 32'd0);
        st(0, "str.geta", C_GETA);
        chk("str.addr.sximm5", 32'(a_sximm5), 32'hFFF8);
        st(0, "str.addr", C_ADDR);
        st(0, "str.laddr", C_LADDR);
        chk("str.getrd.readnum", 32'(a_readnum), 32'd3);
        st(0, "str.getrd", C_GETRD);
        chk("str.passb.shift", 32'(a_shift), 32'd0);
        st(0, "str.passb", C_PASSB);
        st(0, "str.memwr", C_MEMWR);

`ifdef CPU_BRANCH_EN
        status_a = 3'b001;
        fetch(0, "beqt", 16'h2103, 1);
        chk("beqt.sximm8", 32'(a_sximm8), 32'h0003);
        st(0, "beqt.branch", C_BR);
        status_a = 3'b000;
        fetch(0, "beqn", 16'h2103, 1);
        fetch(0, "hlt", 16'hE000, 1);
`else
        fetch(0, "br", 16'h2103, 1);
`endif
        for (int i = 0; i < 20; i++) st(0, "halt.hold", C_HALT);

        #2 reset_n_a = 1'b0;
        #1 chk("arst.halt", 32'(w_ca), 32'(C_RST));
        @(negedge clk);
        reset_n_a = 1'b1;
        @(negedge clk);

        fetch(0, "add2", 16'hA148, 1);
        st(0, "add2.geta", C_GETA);
        st(0, "add2.getb", C_GETB);
        chk("add2.exec", 32'(w_ca), 32'(C_EXEC_ADD));
        #2 reset_n_a = 1'b0;
        #1 chk("arst.exec", 32'(w_ca), 32'(C_RST));
        chk("arst.exec.ir", 32'(a_sximm8), 32'h0);
        @(negedge clk);
        reset_n_a = 1'b1;
        @(negedge clk);

        fetch(0, "bad", 16'h0000, 1);
        st(0, "bad.halt", C_HALT);

        reset_n_b = 1'b1;
        @(negedge clk);
        fetch(1, "ldr", 16'h617F, 3);
        chk("ldr.geta.readnum", 32'(b_readnum), 32'd1);
        chk("ldr.geta.shift", 32'(b_shift), 32'd3);
        st(1, "ldr.geta", C_GETA);
        chk("ldr.addr.sximm5", 32'(b_sximm5), 32'hFFFF);
        chk("ldr.addr.sximm8", 32'(b_sximm8), 32'h007F);
        st(1, "ldr.addr", C_ADDR);
        st(1, "ldr.laddr", C_LADDR);
        for (int i = 0; i < 3; i++) st(1, "ldr.memrd", C_MEMRD);
        chk("ldr.wb.writenum", 32'(b_writenum), 32'd3);
        st(1, "ldr.wbmem", C_WBMEM);
        st(1, "ldr.next", C_IF1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
